avmm_align_pipe_bridge: RTL and testbench

//  Registered AVMM slave->master bridge; shifts off SHIFT low address bits to map byte-addressed PMBus cmds to word addr.

---
 rtl/avmm_align_pkg.sv | 20 ++
 rtl/avmm_timeout_ctr.sv | 30 +++
 rtl/avmm_align_pipe_bridge.sv | 142 ++++++++++++++
 tb/tb_avmm_align_pipe_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_align_pkg.sv
// Shared types for the AVMM alignment bridge.
//   state_t : bridge FSM states (IDLE -> ISSUE -> DONE, or IDLE -> DONE on rejection)
//   op_t    : captured upstream operation
//   DEFAULT_ERR_DATA : read data returned for rejected or abandoned reads
package avmm_align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/avmm_timeout_ctr.sv
// Wait-cycle counter for the bridge's ISSUE state.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart the count at zero (new transaction accepted)
//   enable   : count one more stalled cycle
//   expire   : current count has reached TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES==0)
module avmm_timeout_ctr #(
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (load)   cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end

  // A zero limit disables the watchdog entirely.
  assign expire = (TIMEOUT_CYCLES != 0) && (cnt == CW'(LIMIT));

endmodule

// File: rtl/avmm_align_pipe_bridge.sv
// Registered AVMM slave->master bridge with byte->word address translation.
// One transaction outstanding: IDLE captures the request, ISSUE drives the
// master until the downstream accepts (or the watchdog fires), DONE releases
// upstream waitrequest for exactly one cycle.
//   CLOCK / RESET          : clock, synchronous active-high reset
//   AVS_S0_*               : upstream slave port (byte addressed)
//   AVM_S0_*               : downstream master port (word addressed, all registered)
//   ERR_CLEAR              : pulse clearing the sticky flags (a same-cycle set wins)
//   ERR_ALIGN, ERR_TIMEOUT : sticky error flags
module avmm_align_pipe_bridge
  import avmm_align_pkg::*;
#(
  parameter  int                S_ADDR_W       = 10,
  parameter  int                SHIFT          = 2,
  parameter  int                DATA_W         = 32,
  parameter  bit                STRICT_ALIGN   = 1'b1,
  parameter  int                TIMEOUT_CYCLES = 256,
  parameter  logic [DATA_W-1:0] ERR_DATA       = DATA_W'(DEFAULT_ERR_DATA),
  localparam int                M_ADDR_W       = S_ADDR_W - SHIFT,
  localparam int                BE_W           = DATA_W / 8
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                AVS_S0_READ,
  input  logic                AVS_S0_WRITE,
  input  logic [S_ADDR_W-1:0] AVS_S0_ADDRESS,
  input  logic [BE_W-1:0]     AVS_S0_BYTEEN,
  input  logic [DATA_W-1:0]   AVS_S0_WRITEDATA,
  output logic [DATA_W-1:0]   AVS_S0_READDATA,
  output logic                AVS_S0_WAITREQUEST,
  output logic                AVM_S0_READ,
  output logic                AVM_S0_WRITE,
  output logic [M_ADDR_W-1:0] AVM_S0_ADDRESS,
  output logic [BE_W-1:0]     AVM_S0_BYTEEN,
  output logic [DATA_W-1:0]   AVM_S0_WRITEDATA,
  input  logic [DATA_W-1:0]   AVM_S0_READDATA,
  input  logic                AVM_S0_WAITREQUEST,
  input  logic                ERR_CLEAR,
  output logic                ERR_ALIGN,
  output logic                ERR_TIMEOUT
);

  localparam logic [S_ADDR_W-1:0] LOW_MASK = S_ADDR_W'((1 << SHIFT) - 1);

  state_t state;
  op_t    op;

  logic req;
  op_t  req_op;
  logic misaligned;
  logic tmo_load, tmo_en, tmo_expire;
  logic set_align, set_tmo;

  assign req = AVS_S0_READ | AVS_S0_WRITE;
  // Read and write together is illegal upstream; the write takes precedence.
  assign req_op     = AVS_S0_WRITE ? OP_WRITE : OP_READ;
  assign misaligned = STRICT_ALIGN && ((AVS_S0_ADDRESS & LOW_MASK) != '0);

  assign tmo_load  = (state == IDLE) && req;
  assign tmo_en    = (state == ISSUE) && AVM_S0_WAITREQUEST;
  assign set_align = (state == IDLE) && req && misaligned;
  assign set_tmo   = (state == ISSUE) && AVM_S0_WAITREQUEST && tmo_expire;

  avmm_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (CLOCK),
    .rst   (RESET),
    .load  (tmo_load),
    .enable(tmo_en),
    .expire(tmo_expire)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state              <= IDLE;
      op                 <= OP_READ;
      AVS_S0_WAITREQUEST <= 1'b1;
      AVS_S0_READDATA    <= '0;
      AVM_S0_READ        <= 1'b0;
      AVM_S0_WRITE       <= 1'b0;
      AVM_S0_ADDRESS     <= '0;
      AVM_S0_BYTEEN      <= '0;
      AVM_S0_WRITEDATA   <= '0;
      ERR_ALIGN          <= 1'b0;
      ERR_TIMEOUT        <= 1'b0;
    end else begin
      // Sticky flags: a new error in the clearing cycle keeps the flag set.
      ERR_ALIGN   <= set_align | (ERR_ALIGN & ~ERR_CLEAR);
      ERR_TIMEOUT <= set_tmo | (ERR_TIMEOUT & ~ERR_CLEAR);

      case (state)
        IDLE: begin
          if (req) begin
            op               <= req_op;
            AVM_S0_ADDRESS   <= AVS_S0_ADDRESS[S_ADDR_W-1:SHIFT];
            AVM_S0_BYTEEN    <= AVS_S0_BYTEEN;
            AVM_S0_WRITEDATA <= AVS_S0_WRITEDATA;
            if (misaligned) begin
              // Rejected locally: nothing goes downstream.
              state              <= DONE;
              AVS_S0_WAITREQUEST <= 1'b0;
              if (req_op == OP_READ) AVS_S0_READDATA <= ERR_DATA;
            end else begin
              state        <= ISSUE;
              AVM_S0_READ  <= (req_op == OP_READ);
              AVM_S0_WRITE <= (req_op == OP_WRITE);
            end
          end
        end

        ISSUE: begin
          if (!AVM_S0_WAITREQUEST) begin
            state              <= DONE;
            AVS_S0_WAITREQUEST <= 1'b0;
            AVM_S0_READ        <= 1'b0;
            AVM_S0_WRITE       <= 1'b0;
            if (op == OP_READ) AVS_S0_READDATA <= AVM_S0_READDATA;
          end else if (tmo_expire) begin
            // Hung slave: abandon the access and complete upstream with error data.
            state              <= DONE;
            AVS_S0_WAITREQUEST <= 1'b0;
            AVM_S0_READ        <= 1'b0;
            AVM_S0_WRITE       <= 1'b0;
            if (op == OP_READ) AVS_S0_READDATA <= ERR_DATA;
          end
        end

        DONE: begin
          state              <= IDLE;
          AVS_S0_WAITREQUEST <= 1'b1;
        end

        default: begin
          state              <= IDLE;
          AVS_S0_WAITREQUEST <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_align_pipe_bridge.sv
module tb_avmm_align_pipe_bridge;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        avs_read, avs_write;
  logic [9:0]  avs_addr;
  logic [3:0]  avs_be;
  logic [31:0] avs_wdata;
  logic [31:0] avs_rdata, lax_avs_rdata;
  logic        avs_waitreq, lax_avs_waitreq;
  logic        avm_read, avm_write, lax_avm_read, lax_avm_write;
  logic [7:0]  avm_addr, lax_avm_addr;
  logic [3:0]  avm_be, lax_avm_be;
  logic [31:0] avm_wdata, lax_avm_wdata;
  logic [31:0] ds_rdata;
  logic        avm_waitreq;
  logic        err_clear;
  logic        err_align, err_timeout, lax_err_align, lax_err_timeout;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];

  always #5 CLOCK = ~CLOCK;

  avmm_align_pipe_bridge #(.STRICT_ALIGN(1'b1), .TIMEOUT_CYCLES(8)) u_dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .AVS_S0_READ(avs_read), .AVS_S0_WRITE(avs_write), .AVS_S0_ADDRESS(avs_addr),
    .AVS_S0_BYTEEN(avs_be), .AVS_S0_WRITEDATA(avs_wdata),
    .AVS_S0_READDATA(avs_rdata), .AVS_S0_WAITREQUEST(avs_waitreq),
    .AVM_S0_READ(avm_read), .AVM_S0_WRITE(avm_write), .AVM_S0_ADDRESS(avm_addr),
    .AVM_S0_BYTEEN(avm_be), .AVM_S0_WRITEDATA(avm_wdata),
    .AVM_S0_READDATA(ds_rdata), .AVM_S0_WAITREQUEST(avm_waitreq),
    .ERR_CLEAR(err_clear), .ERR_ALIGN(err_align), .ERR_TIMEOUT(err_timeout)
  );

  // Same stimulus into a non-strict instance to observe low-bit dropping.
  avmm_align_pipe_bridge #(.STRICT_ALIGN(1'b0), .TIMEOUT_CYCLES(8)) u_dut_lax (
    .CLOCK(CLOCK), .RESET(RESET),
    .AVS_S0_READ(avs_read), .AVS_S0_WRITE(avs_write), .AVS_S0_ADDRESS(avs_addr),
    .AVS_S0_BYTEEN(avs_be), .AVS_S0_WRITEDATA(avs_wdata),
    .AVS_S0_READDATA(lax_avs_rdata), .AVS_S0_WAITREQUEST(lax_avs_waitreq),
    .AVM_S0_READ(lax_avm_read), .AVM_S0_WRITE(lax_avm_write), .AVM_S0_ADDRESS(lax_avm_addr),
    .AVM_S0_BYTEEN(lax_avm_be), .AVM_S0_WRITEDATA(lax_avm_wdata),
    .AVM_S0_READDATA(ds_rdata), .AVM_S0_WAITREQUEST(avm_waitreq),
    .ERR_CLEAR(err_clear), .ERR_ALIGN(lax_err_align), .ERR_TIMEOUT(lax_err_timeout)
  );

  // Downstream slave model: stalls ds_waits cycles per access, or forever when stuck.
  int ds_waits;
  bit ds_stuck;
  int ds_cnt = 0;
  assign avm_waitreq = ds_stuck | ((avm_read | avm_write) && (ds_cnt < ds_waits));
  always @(posedge CLOCK) begin
    if (!(avm_read | avm_write)) ds_cnt <= 0;
    else if (avm_waitreq)        ds_cnt <= ds_cnt + 1;
  end

  // Master-side monitor: free-running counters, snapshots taken by the stimulus.
  int          rd_hi = 0, wr_hi = 0, moved = 0, ds_wr = 0, lax_rd_hi = 0;
  logic [7:0]  last_addr = '0, lax_last_addr = '0, prev_addr = '0;
  logic        prev_req = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  always @(negedge CLOCK) begin
    if (avm_read)  rd_hi++;
    if (avm_write) wr_hi++;
    if (avm_read | avm_write) begin
      if (prev_req && (avm_addr != prev_addr)) moved++;
      last_addr = avm_addr;
      if (avm_write && !avm_waitreq) begin
        ds_wr++;
        wr_be   = avm_be;
        wr_data = avm_wdata;
      end
    end
    prev_req  = avm_read | avm_write;
    prev_addr = avm_addr;
    if (lax_avm_read) begin
      lax_rd_hi++;
      lax_last_addr = lax_avm_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Drive one upstream request, hold it until completion, then check the
  // DONE pulse is a single cycle. Reads pop the scoreboard at completion.
  task automatic xfer(input bit rd, input bit wr, input logic [9:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output int cyc);
    logic [31:0] exp;
    avs_read = rd; avs_write = wr; avs_addr = a; avs_be = be; avs_wdata = wd;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (avs_waitreq && cyc < 40);
    chk("done_seen", avs_waitreq, 1'b0);
    if (rd && !wr) begin
      if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
      else begin
        exp = sb_q.pop_front();
        chk("rdata", avs_rdata, exp);
      end
    end
    avs_read = 1'b0; avs_write = 1'b0;
    tick();
    chk("one_pulse", avs_waitreq, 1'b1);
  endtask

  int cyc, r0, w0, m0, d0, l0;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; avs_read = 1'b0; avs_write = 1'b0; avs_addr = '0; avs_be = '0;
    avs_wdata = '0; ds_rdata = '0; err_clear = 1'b0; ds_waits = 0; ds_stuck = 1'b0;
    repeat (3) tick();
    chk("rst_waitreq", avs_waitreq, 1'b1);
    chk("rst_rdata", avs_rdata, 32'h0);
    chk("rst_avm_rw", {avm_read, avm_write}, 2'b00);
    chk("rst_avm_addr", avm_addr, 8'h00);
    chk("rst_flags", {err_align, err_timeout}, 2'b00);
    RESET = 1'b0;
    tick();

    // Zero-wait aligned read: DONE after two edges, i.e. the third cycle.
    ds_rdata = 32'h1234_5678; sb_q.push_back(32'h1234_5678);
    r0 = rd_hi;
    xfer(1'b1, 1'b0, 10'h00C, 4'hF, 32'h0, cyc);
    chk("rd_latency", cyc, 2);
    chk("rd_hi_cycles", rd_hi - r0, 1);
    chk("rd_word_addr", last_addr, 8'h03);

    // Write with 4 downstream waits: command held for 5 cycles.
    ds_waits = 4;
    w0 = wr_hi; m0 = moved; d0 = ds_wr;
    xfer(1'b0, 1'b1, 10'h010, 4'b0011, 32'h0000_A5A5, cyc);
    chk("wr_latency", cyc, 6);
    chk("wr_hi_cycles", wr_hi - w0, 5);
    chk("wr_addr_stable", moved - m0, 0);
    chk("wr_word_addr", last_addr, 8'h04);
    chk("wr_accepted", ds_wr - d0, 1);
    chk("wr_be", wr_be, 4'b0011);
    chk("wr_data", wr_data, 32'h0000_A5A5);
    chk("wr_keeps_rdata", avs_rdata, 32'h1234_5678);

    // Misaligned read: strict rejects locally, lax drops the low bits.
    ds_waits = 0;
    sb_q.push_back(32'hDEAD_BEEF);
    r0 = rd_hi; l0 = lax_rd_hi;
    xfer(1'b1, 1'b0, 10'h00D, 4'hF, 32'h0, cyc);
    chk("mis_latency", cyc, 1);
    chk("mis_no_avm_read", rd_hi - r0, 0);
    chk("mis_err_align", err_align, 1'b1);
    chk("mis_no_timeout", err_timeout, 1'b0);
    repeat (2) tick();
    chk("lax_read_issued", lax_rd_hi - l0, 1);
    chk("lax_word_addr", lax_last_addr, 8'h03);

    // Stuck downstream: read abandoned after 8 ISSUE cycles.
    ds_stuck = 1'b1;
    sb_q.push_back(32'hDEAD_BEEF);
    r0 = rd_hi;
    xfer(1'b1, 1'b0, 10'h020, 4'hF, 32'h0, cyc);
    ds_stuck = 1'b0;
    chk("tmo_latency", cyc, 9);
    chk("tmo_rd_hi_cycles", rd_hi - r0, 8);
    chk("tmo_err_timeout", err_timeout, 1'b1);
    chk("tmo_align_kept", err_align, 1'b1);
    repeat (2) tick();

    // Read and write together: only the write goes out, readdata untouched.
    r0 = rd_hi; d0 = ds_wr;
    xfer(1'b1, 1'b1, 10'h014, 4'hF, 32'hCAFE_F00D, cyc);
    chk("rw_no_read", rd_hi - r0, 0);
    chk("rw_write_done", ds_wr - d0, 1);
    chk("rw_wdata", wr_data, 32'hCAFE_F00D);
    chk("rw_keeps_rdata", avs_rdata, 32'hDEAD_BEEF);

    // ERR_CLEAR on the same edge as a new timeout: timeout stays, align clears.
    ds_stuck = 1'b1;
    avs_read = 1'b1; avs_addr = 10'h024;
    repeat (8) @(posedge CLOCK);
    #1;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clr_tmo_done", avs_waitreq, 1'b0);
    chk("clr_tmo_set_wins", err_timeout, 1'b1);
    chk("clr_align_cleared", err_align, 1'b0);
    chk("clr_tmo_rdata", avs_rdata, 32'hDEAD_BEEF);
    avs_read = 1'b0; ds_stuck = 1'b0;
    repeat (2) tick();

    // ERR_CLEAR alone.
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clr_alone", {err_align, err_timeout}, 2'b00);

    // Misaligned write: dropped, flag set.
    d0 = ds_wr;
    xfer(1'b0, 1'b1, 10'h011, 4'hF, 32'h1111_2222, cyc);
    chk("miswr_dropped", ds_wr - d0, 0);
    chk("miswr_err_align", err_align, 1'b1);
    repeat (2) tick();

    // Reset two cycles into ISSUE.
    ds_stuck = 1'b1;
    avs_read = 1'b1; avs_addr = 10'h028;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    chk("rst_mid_avm_read", avm_read, 1'b0);
    chk("rst_mid_waitreq", avs_waitreq, 1'b1);
    chk("rst_mid_flags", {err_align, err_timeout}, 2'b00);
    RESET = 1'b0; avs_read = 1'b0; ds_stuck = 1'b0;
    tick();

    // Normal read after reset.
    ds_rdata = 32'h0BAD_F00D; sb_q.push_back(32'h0BAD_F00D);
    xfer(1'b1, 1'b0, 10'h030, 4'hF, 32'h0, cyc);
    chk("post_rst_latency", cyc, 2);
    chk("post_rst_addr", last_addr, 8'h0C);
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
